// File: rtl/charge_session_ctrl.sv
// charge_session_ctrl: coin-credited charging outlet sequencer with a BCD M:SS countdown and relay control.
// Define GRACE_PERIOD_EN to pause on unplug for up to GRACE_TICKS seconds instead of ending the session.
module charge_session_ctrl #(
    parameter int TICK_DIV    = 50000000,
    parameter int GRACE_TICKS = 30
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [2:0]  Coin,
    input  logic        Start,
    input  logic        Stop,
    input  logic        PlugIn,
    output logic [11:0] PresentTime,
    output logic        Relay,
    output logic [2:0]  State,
    output logic        Done,
    output logic        CoinReject
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CREDIT   = 3'd1,
        CHARGING = 3'd2,
        PAUSED   = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [9:0] MAX_SECS = 10'd599;

    if (TICK_DIV < 2 || GRACE_TICKS < 1) begin : g_bad_params
        $error("charge_session_ctrl: TICK_DIV must be >= 2 and GRACE_TICKS >= 1");
    end

    state_t        state, next_state;
    logic [9:0]    secs, next_secs;
    logic [TW-1:0] tick_cnt, next_tick_cnt;
    logic          coin_seen, relay_q, done_q, reject_q;
    logic          coin_event, coin_valid, tick, dec;
    logic [9:0]    credit, topped;
    logic [10:0]   sum;

    // Remaining time is kept as plain seconds; BCD is only produced for the display.
    function automatic logic [11:0] to_bcd(input logic [9:0] s);
        logic [9:0] r;
        r = s % 10'd60;
        return {4'(s / 10'd60), 4'(r / 10'd10), 4'(r % 10'd10)};
    endfunction

    assign coin_event = !coin_seen && Coin != 3'd0;
    assign coin_valid = coin_event && Coin <= 3'd4;
    assign credit     = !coin_valid    ? 10'd0   :
                        Coin == 3'd1   ? 10'd30  :
                        Coin == 3'd2   ? 10'd60  :
                        Coin == 3'd3   ? 10'd150 : 10'd300;
    assign tick       = tick_cnt == TW'(TICK_DIV - 1);
    assign dec        = state == CHARGING && tick && secs != 10'd0;
    assign sum        = {1'b0, secs} - {10'd0, dec} + {1'b0, credit};
    assign topped     = sum > {1'b0, MAX_SECS} ? MAX_SECS : sum[9:0];

`ifdef GRACE_PERIOD_EN
    localparam int GW = $clog2(GRACE_TICKS + 1);
    logic [TW-1:0] grace_cnt, next_grace_cnt;
    logic [GW-1:0] grace_secs, next_grace_secs;
    logic          grace_tick;
    assign grace_tick = grace_cnt == TW'(TICK_DIV - 1);
`endif

    always_comb begin
        next_state    = state;
        next_secs     = secs;
        next_tick_cnt = tick_cnt;
`ifdef GRACE_PERIOD_EN
        next_grace_cnt  = grace_cnt;
        next_grace_secs = grace_secs;
`endif
        case (state)
            IDLE: begin
                next_secs = 10'd0;
                if (coin_valid) begin
                    next_state = CREDIT;
                    next_secs  = topped;
                end
            end
            CREDIT: begin
                next_secs = topped;
                if (Start && PlugIn) begin
                    next_state    = CHARGING;
                    next_tick_cnt = '0;
                end
            end
            CHARGING: begin
                if (Stop) begin
                    next_state = DONE;
                    next_secs  = 10'd0;
                end else if (!PlugIn) begin
`ifdef GRACE_PERIOD_EN
                    next_state      = PAUSED;
                    next_grace_cnt  = '0;
                    next_grace_secs = '0;
`else
                    next_state = DONE;
                    next_secs  = 10'd0;
`endif
                end else begin
                    next_tick_cnt = tick ? '0 : tick_cnt + TW'(1);
                    next_secs     = topped;
                    // a same-cycle coin keeps the session alive even at 0:01
                    if (topped == 10'd0)
                        next_state = DONE;
                end
            end
`ifdef GRACE_PERIOD_EN
            PAUSED: begin
                next_grace_cnt  = grace_tick ? '0 : grace_cnt + TW'(1);
                next_grace_secs = grace_secs + GW'(grace_tick);
                if (Stop) begin
                    next_state = DONE;
                    next_secs  = 10'd0;
                end else if (PlugIn) begin
                    next_state = CHARGING;
                    next_secs  = topped;
                end else if (grace_tick && grace_secs == GW'(GRACE_TICKS - 1)) begin
                    next_state = DONE;
                    next_secs  = 10'd0;
                end else begin
                    next_secs = topped;
                end
            end
`endif
            DONE: begin
                next_secs = 10'd0;
                if (!PlugIn)
                    next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                next_secs  = 10'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state     <= IDLE;
            secs      <= 10'd0;
            tick_cnt  <= '0;
            coin_seen <= 1'b0;
            relay_q   <= 1'b0;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state     <= next_state;
            secs      <= next_secs;
            tick_cnt  <= next_tick_cnt;
            coin_seen <= Coin != 3'd0;
            relay_q   <= next_state == CHARGING;
            done_q    <= next_state == DONE && state != DONE;
            reject_q  <= coin_event && (!coin_valid || state == DONE);
        end
    end

`ifdef GRACE_PERIOD_EN
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            grace_cnt  <= '0;
            grace_secs <= '0;
        end else begin
            grace_cnt  <= next_grace_cnt;
            grace_secs <= next_grace_secs;
        end
    end
`endif

    assign PresentTime = to_bcd(secs);
    assign Relay       = relay_q;
    assign State       = state;
    assign Done        = done_q;
    assign CoinReject  = reject_q;
endmodule
